// File: rtl/rr_mux_8x1_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_8x1_if
// Description : Bundle of the eight producer valid/ready/data lanes and the
//               single merged output lane (data + 3-bit channel select).
//               modport slave  : the multiplexer side
//               modport master : the environment side (producers + consumer)
// Ports       : in_valid[8], in_data[8*DW], in_ready[8],
//               out_valid, out_ready, out_data[DW], out_sel[3]
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_8x1_if #(
  parameter int DW = 8
);
  logic [7:0]      in_valid;
  logic [8*DW-1:0] in_data;
  logic [7:0]      in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_sel
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_sel
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux_8x1.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_8x1
// Description : Eight-channel round-robin 8:1 multiplexer with valid/ready
//               handshakes and one registered output stage. Each output beat
//               carries the data word and the index of the channel it came
//               from so a downstream 1x8 demux can redistribute it.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - rr_mux_8x1_if.slave (8 input lanes + 1 output lane)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_8x1 #(
  parameter int DW  = 8,
  parameter int NCH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  rr_mux_8x1_if.slave bus
);

  localparam int c_SEL_W = 3;

  // Output register stage and round-robin pointer
  logic               r_out_valid;
  logic [DW-1:0]      r_out_data;
  logic [c_SEL_W-1:0] r_out_sel;
  logic [c_SEL_W-1:0] r_ptr;

  // Arbitration
  logic               w_load_en;
  logic               w_gnt_found;
  logic [c_SEL_W-1:0] w_gnt_idx;
  logic [c_SEL_W-1:0] w_cand;
  logic [NCH-1:0]     w_ready;
  logic               w_xfer;
  logic [DW-1:0]      w_gnt_data;

  // The output slot can take a new beat when it is empty or being drained this
  // cycle. Gating with rst_n keeps in_ready low while reset is held.
  assign w_load_en = rst_n & (~r_out_valid | bus.out_ready);

  // Search ptr, ptr+1, ... ptr+7 (3-bit arithmetic wraps naturally) and take
  // the first requesting channel.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = r_ptr + c_SEL_W'(k);
      if (!w_gnt_found && bus.in_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // One-hot ready to the granted channel only.
  always_comb begin
    w_ready = '0;
    if (w_gnt_found && w_load_en) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_xfer     = w_gnt_found & w_load_en;
  // Only the granted lane is selected, so other lanes' data (even X) never
  // reaches the output register.
  assign w_gnt_data = bus.in_data[w_gnt_idx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      // Load (possibly replacing a beat drained in the same cycle: no bubble).
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_sel   <= w_gnt_idx;
      r_ptr       <= w_gnt_idx + 1'b1;
    end else if (bus.out_ready) begin
      // Drain with nothing to load; data/sel keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_8x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_8x1
// Description : Directed self-checking bench for rr_mux_8x1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_8x1;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_mux_8x1_if #(.DW(DW)) bus ();

  rr_mux_8x1 #(.DW(DW), .NCH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] val);
    bus.in_data[ch*DW +: DW] = val;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b0;
    bus.in_data   = {8{8'hEE}};
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.out_sel !== 3'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", bus.out_sel); end
    checks++; if (bus.in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%b exp=00000000", bus.in_ready); end
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.in_data  = {8{8'hEE}};
    set_data(5, 8'hA5);
    bus.in_valid = 8'h20;
    #1;
    checks++; if (bus.in_ready !== 8'b0010_0000) begin failures++; $display("FAIL single_in_ready got=%b exp=00100000", bus.in_ready); end
    tick();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd5 || bus.out_data !== 8'hA5) begin
      failures++; $display("FAIL single_beat got v=%b sel=%0d d=%h exp v=1 sel=5 d=a5", bus.out_valid, bus.out_sel, bus.out_data);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd5 || bus.out_data !== 8'hA5) begin
      failures++; $display("FAIL single_drain got v=%b sel=%0d d=%h exp v=0 sel=5 d=a5", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    // Bring the pointer back to 0 with an asynchronous reset pulse.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) set_data(i, 8'h10 + 8'(i));
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'(c % 8) || bus.out_data !== 8'h10 + 8'(c % 8)) begin
        failures++;
        $display("FAIL rr_beat%0d got v=%b sel=%0d d=%h exp v=1 sel=%0d d=%h", c, bus.out_valid, bus.out_sel,
                 bus.out_data, c % 8, 8'h10 + 8'(c % 8));
      end
    end
    bus.in_valid = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    // Pointer is at 2 after the round-robin run.
    set_data(2, 8'h33);
    bus.in_valid = 8'h04;
    tick();
    checks++; if (bus.out_sel !== 3'd2 || bus.out_data !== 8'h33) begin
      failures++; $display("FAIL bp_load got sel=%0d d=%h exp sel=2 d=33", bus.out_sel, bus.out_data);
    end
    bus.out_ready = 1'b0;
    set_data(3, 8'h43);
    set_data(6, 8'h46);
    bus.in_valid = 8'h48;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b1 || bus.out_sel !== 3'd2 || bus.out_data !== 8'h33) begin
        failures++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b sel=%0d d=%h exp rdy=00000000 v=1 sel=2 d=33", c, bus.in_ready,
                 bus.out_valid, bus.out_sel, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'b0000_1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=00001000", bus.in_ready); end
    tick();
    bus.in_valid = 8'h40;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd3 || bus.out_data !== 8'h43) begin
      failures++; $display("FAIL bp_next1 got v=%b sel=%0d d=%h exp v=1 sel=3 d=43", bus.out_valid, bus.out_sel, bus.out_data);
    end
    tick();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd6 || bus.out_data !== 8'h46) begin
      failures++; $display("FAIL bp_next2 got v=%b sel=%0d d=%h exp v=1 sel=6 d=46", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_wrap_skip();
    // Pointer is 7 after the channel-6 grant.
    set_data(0, 8'hC0);
    set_data(2, 8'hC2);
    bus.in_valid = 8'h05;
    tick();
    bus.in_valid = 8'h04;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 8'hC0) begin
      failures++; $display("FAIL wrap_ch0 got v=%b sel=%0d d=%h exp v=1 sel=0 d=c0", bus.out_valid, bus.out_sel, bus.out_data);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd2 || bus.out_data !== 8'hC2) begin
      failures++; $display("FAIL wrap_ch2 got v=%b sel=%0d d=%h exp v=1 sel=2 d=c2", bus.out_valid, bus.out_sel, bus.out_data);
    end
    // With ptr=3, channel 3 must win over 0 and 2.
    bus.in_valid = 8'h0D;
    #1;
    checks++; if (bus.in_ready !== 8'b0000_1000) begin failures++; $display("FAIL wrap_ptr3 got=%b exp=00001000", bus.in_ready); end
    bus.in_valid = 8'h00;
    tick();
  endtask

  task automatic test_mid_reset();
    set_data(4, 8'h54);
    set_data(7, 8'h57);
    bus.in_valid = 8'h10;
    tick();
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd4) begin
      failures++; $display("FAIL mid_pre got v=%b sel=%0d exp v=1 sel=4", bus.out_valid, bus.out_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd0 || bus.out_data !== 8'h00) begin
      failures++; $display("FAIL mid_async got v=%b sel=%0d d=%h exp v=0 sel=0 d=00", bus.out_valid, bus.out_sel, bus.out_data);
    end
    #1;
    rst_n         = 1'b1;
    bus.in_valid  = 8'h90;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'b0001_0000) begin failures++; $display("FAIL mid_first_ready got=%b exp=00010000", bus.in_ready); end
    tick();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd4 || bus.out_data !== 8'h54) begin
      failures++; $display("FAIL mid_first_beat got v=%b sel=%0d d=%h exp v=1 sel=4 d=54", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: all stimulus is fixed-length, so this should never trigger.
  initial begin
    #100000;
    $display("FAIL timeout reached at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_8x1.md
Name: rr_mux_8x1

Overview:
- Eight-channel, round-robin, registered 8:1 multiplexer with valid/ready handshakes on every port.
- Functional inverse of the team's 1x8 demux: it merges eight producer streams into one output stream.
- Each output beat carries the data word and a 3-bit channel select, matching the demux D/S pair, so the demux can redistribute the beat downstream.
- Sits between per-channel producers and a shared single-lane consumer (serial link, shared bus, or demux).

Parameters:
- DW, 8, data width per channel in bits (must be >= 1)
- NCH, 8, number of channels; fixed at 8; select width is 3

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  8  per-channel valid; bit i belongs to channel i
- in_data  input  8*DW  channel i data at bits [i*DW +: DW]
- in_ready  output  8  per-channel ready; at most one bit high per cycle
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  DW  data of the granted channel
- out_sel  output  3  channel index of out_data (0..7)

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0, in_ready=0.
- Output stage: one register stage holding {out_valid, out_data, out_sel}.
- load_en = !out_valid | out_ready. This is combinational; in_ready depends on out_ready.
- Arbitration (combinational):
  - grant = first channel j, searching j = ptr, ptr+1, ..., ptr+7 mod 8, with in_valid[j]=1.
  - in_ready[grant] = load_en. All other in_ready bits are 0.
  - If no in_valid bit is set, there is no grant and in_ready = 0.
- Transfer on channel j: in_valid[j] & in_ready[j] at a rising edge. That edge:
  - sets out_valid=1
  - sets out_data = in_data[j*DW +: DW]
  - sets out_sel = j
  - sets ptr = (j+1) mod 8, wrapping 7 -> 0
- Latency: 1 cycle from input handshake to out_valid. Throughput is one beat per cycle when out_ready is held high.
- Drain: out_valid & out_ready with no input transfer in the same cycle -> out_valid=0 next cycle. out_data and out_sel hold their last values.
- Simultaneous drain and load: the new beat replaces the old one with no bubble. out_valid stays 1.
- Stall: out_valid=1 & out_ready=0 -> out_data, out_sel, out_valid and ptr are held stable, and in_ready=0.
- ptr changes only on an input transfer. Idle cycles and stalled cycles do not advance it.
- Fairness: a channel with continuous in_valid is granted within 8 accepted beats.
- Protocol assumptions on producers:
  - In_data and in_valid stay stable until the handshake completes.
  - The block does not depend on this for correctness; it samples only on the transfer edge.
- Reset asserted mid-stream: the held beat is discarded, and all outputs return to reset values immediately (asynchronously).
- Reset release: the first grant goes to the lowest requesting index >= 0.
- X-safety: in_data of non-granted channels never affects outputs.

Test Plan:
- Reset check: rst_n=0 with all in_valid=8'hFF -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Then release rst_n with out_ready=1.
- Single channel: only channel 5 valid, data=8'hA5, out_ready=1 -> in_ready=8'b0010_0000. Next cycle out_valid=1, out_sel=3'd5, out_data=8'hA5.
- Full round-robin: in_valid=8'hFF, channel i data=8'h10+i, out_ready=1 for 10 cycles -> out_sel sequence 0,1,...,7,0,1 with matching data, and no bubbles.
- Backpressure: beat from channel 2 (8'h33) pending with out_ready=0 for 4 cycles, channels 3 and 6 valid -> outputs held at sel=2/8'h33 and in_ready=0. After out_ready=1, the next beats are sel=3, then sel=6.
- Wrap and skip: ptr=7 after a grant of channel 6, in_valid=8'b0000_0101 -> grants channel 0 then 2, and ptr ends at 3.
- Mid-stream reset: rst_n pulsed low while out_valid=1 (sel=4) -> out_valid drops to 0 immediately. After release with in_valid=8'h90, the first grant is channel 4.
